trs80_keyboard: RTL
===================

# trs80_keyboard

PS/2-to-TRS-80 keyboard matrix emulator. Receives PS/2 scancodes from the host keyboard and maintains an 8×8 key matrix mirroring the Model I keyboard. It answers CPU reads in the $3800-$3BFF window: the glue block asserts `keyboard_cs_n`, and this block drives `keyboard_dout`, the OR of all matrix rows selected by address bits A7..A0.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronized `ps2_clk` samples required before the filtered clock changes.
- `TIMEOUT_CYCLES`, default 50000: idle clocks allowed between bits inside a frame before the receiver aborts (about 2 ms at 25 MHz).
- `clock` input, 1 bit: system clock, rising edge.
- `reset` input, 1 bit: asynchronous reset, active-high.
- `ps2_clk` input, 1 bit: raw PS/2 clock, asynchronous to `clock`.
- `ps2_data` input, 1 bit: raw PS/2 data, asynchronous to `clock`.
- `cpu_addr` input, 8 bits: CPU A7..A0; bit n high selects matrix row n.
- `keyboard_cs_n` input, 1 bit: active-low select from glue.
- `keyboard_dout` output, 8 bits: selected row data; 1 = key pressed.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - The filtered clock toggles only after `FILTER_LEN` consecutive equal samples.
  - A falling edge of the filtered clock is the bit strobe. Data is sampled on the synchronized `ps2_data` in the same cycle as the strobe.
- Receiver FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on a strobe, go to DATA if data=0 (start bit). Stay in IDLE if data=1.
  - DATA: shift in 8 bits, LSB first, using a 3-bit counter. After bit 7, go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: on a strobe, the byte is accepted if stop=1 and the parity bit makes the 9 bits odd. An accepted byte raises a one-cycle `byte_valid`. Otherwise the byte is dropped. Either way, return to IDLE.
  - Timeout: in any state other than IDLE, if `TIMEOUT_CYCLES` clocks pass with no strobe, return to IDLE and drop the partial byte.
- Decoder holds two flags, `ext` and `brk`, and acts on each `byte_valid`:
  - E0: set `ext`.
  - F0: set `brk`.
  - AA with both flags clear: keyboard self-test passed; clear the whole matrix.
  - Any other code: look up (`ext`, code) in the keymap. On a hit, write matrix[row][col] = !`brk`. Then clear both flags, whether or not the lookup hit.
  - Parity, framing or timeout errors clear both flags.
- Keymap minimum set (row/bit):
  - Row 0: @=0E → 0/0, A..G = 1C,32,21,23,24,2B,34 → 0/1..7.
  - Row 1: H..O → 1/0..7.
  - Row 2: P..W → 2/0..7.
  - Row 3: X,Y,Z = 22,35,1A → 3/0..2.
  - Row 4: 0..7 = 45,16,1E,26,25,2E,36,3D → 4/0..7.
  - Row 5: 8,9 = 3E,46 → 5/0,1; ' 52 (:) → 5/2; ; 4C → 5/3; , 41 → 5/4; - 4E → 5/5; . 49 → 5/6; / 4A → 5/7.
  - Row 6: ENTER 5A or E0 5A → 6/0; CLEAR E0 6C (Home) → 6/1; BREAK 76 (Esc) → 6/2; UP E0 75 → 6/3; DOWN E0 72 → 6/4; LEFT E0 6B → 6/5; RIGHT E0 74 → 6/6; SPACE 29 → 6/7.
  - Row 7: left SHIFT 12 and right SHIFT 59 → 7/0.
- Read path (combinational):
  - `keyboard_dout` = OR of matrix[n] for every n with `cpu_addr[n]`=1.
  - Forced to 00 when `keyboard_cs_n`=1 or `cpu_addr`=00.

## Timing
- Reset:
  - FSM goes to IDLE.
  - Flags, matrix, bit counter, shift register and timeout counter clear.
  - Filtered clock and synchronizers reset to 1.
  - `keyboard_dout` = 00.
- Latency: from the internal strobe of a valid stop bit to `byte_valid` is 1 cycle. The matrix register updates on the next edge, so the new value is visible on `keyboard_dout` 2 cycles after the strobe.
- The read path has zero cycle latency relative to `cpu_addr` and `keyboard_cs_n`.
- A strobe and a timeout expiring in the same cycle: the strobe wins.
- A reset asserted mid-frame abandons the frame; the first post-reset falling edge is treated as a potential start bit.
- Repeated make codes (typematic) rewrite the same bit; this is idempotent.

## Structure
- Package `trs80_kbd_pkg`:
  - receiver state enum;
  - scancode constants E0, F0, AA;
  - 3-bit row and column types;
  - defaults for `FILTER_LEN` and `TIMEOUT_CYCLES`.
- Sub-module `trs80_keymap`: combinational map from {`ext`, code[7:0]} to {hit, row[2:0], col[2:0]}.
- Top level holds the synchronizers, filter, receiver FSM, decoder flags, 64-bit matrix and read mux.

## Test plan
- Frame 1C → A pressed:
  - Send 1C with correct parity, then read with `cpu_addr`=01 and `keyboard_cs_n`=0. Required: `keyboard_dout`=02.
  - Then send F0 1C. Required: 00.
- Extended key and row mask:
  - Send E0 75. With `cpu_addr`=40, required 08.
  - Also hold SPACE (29). With `cpu_addr`=C0, required 88.
- Shift plus digit:
  - Send 12 then 16. With `cpu_addr`=90, required 03.
  - Send F0 12. Required 02.
- Bad parity:
  - Send 1C with even parity. Required: matrix unchanged.
  - A following valid 33 sets row 1 bit 0 (`cpu_addr`=02 → 01).
- Timeout:
  - Stop clocking after 4 data bits and wait `TIMEOUT_CYCLES`+1 clocks.
  - Then send a full 29 frame. Required: `cpu_addr`=40 → 80.
- Clear and reset:
  - Press A and H, then send AA. Required: `cpu_addr`=FF → 00.
  - Press A, then pulse `reset` mid-frame. Required: `keyboard_dout`=00 immediately, and `keyboard_cs_n`=1 always yields 00.

Source files
------------

// File: rtl/trs80_kbd_pkg.sv
// Shared types and constants for the TRS-80 keyboard matrix emulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trs80_kbd_pkg;

  // PS/2 receiver frame position
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Scancodes with special meaning to the decoder
  localparam logic [7:0] SC_EXT    = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_BRK    = 8'hF0;  // key-release prefix
  localparam logic [7:0] SC_BAT_OK = 8'hAA;  // keyboard self-test passed

  typedef logic [2:0] row_t;
  typedef logic [2:0] col_t;

  localparam int FILTER_LEN_DEFAULT     = 8;
  localparam int TIMEOUT_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/trs80_keyboard_if.sv
// CPU-side read port of the keyboard matrix ($3800-$3BFF window).
// Latency: combinational read, zero cycles from address/select to data.
// Backpressure: none; the read is always answered.
//   cpu_addr      : A7..A0, bit n selects matrix row n
//   keyboard_cs_n : active-low select from the address decode glue
//   keyboard_dout : OR of the selected rows, 1 = key pressed
interface trs80_keyboard_if;
  logic [7:0] cpu_addr;
  logic       keyboard_cs_n;
  logic [7:0] keyboard_dout;

  modport master (output cpu_addr, output keyboard_cs_n, input keyboard_dout);
  modport slave  (input cpu_addr, input keyboard_cs_n, output keyboard_dout);
endinterface

// File: rtl/trs80_keymap.sv
// Maps {ext, scancode} to a Model I matrix position (row/col) plus a hit flag.
// Latency: purely combinational.
// Backpressure: none.
//   ext  : scancode was preceded by E0
//   code : set-2 scancode byte
//   hit  : code is a mapped key; row/col valid only when set
module trs80_keymap
  import trs80_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output row_t       row,
  output col_t       col
);

  // Octal literal nn reads directly as row n, column n
  logic [5:0] rc;

  always_comb begin
    hit = 1'b1;
    rc  = 6'o00;
    if (!ext) begin
      case (code)
        8'h0E: rc = 6'o00; 8'h1C: rc = 6'o01; 8'h32: rc = 6'o02; 8'h21: rc = 6'o03;
        8'h23: rc = 6'o04; 8'h24: rc = 6'o05; 8'h2B: rc = 6'o06; 8'h34: rc = 6'o07;
        8'h33: rc = 6'o10; 8'h43: rc = 6'o11; 8'h3B: rc = 6'o12; 8'h42: rc = 6'o13;
        8'h4B: rc = 6'o14; 8'h3A: rc = 6'o15; 8'h31: rc = 6'o16; 8'h44: rc = 6'o17;
        8'h4D: rc = 6'o20; 8'h15: rc = 6'o21; 8'h2D: rc = 6'o22; 8'h1B: rc = 6'o23;
        8'h2C: rc = 6'o24; 8'h3C: rc = 6'o25; 8'h2A: rc = 6'o26; 8'h1D: rc = 6'o27;
        8'h22: rc = 6'o30; 8'h35: rc = 6'o31; 8'h1A: rc = 6'o32;
        8'h45: rc = 6'o40; 8'h16: rc = 6'o41; 8'h1E: rc = 6'o42; 8'h26: rc = 6'o43;
        8'h25: rc = 6'o44; 8'h2E: rc = 6'o45; 8'h36: rc = 6'o46; 8'h3D: rc = 6'o47;
        8'h3E: rc = 6'o50; 8'h46: rc = 6'o51; 8'h52: rc = 6'o52; 8'h4C: rc = 6'o53;
        8'h41: rc = 6'o54; 8'h4E: rc = 6'o55; 8'h49: rc = 6'o56; 8'h4A: rc = 6'o57;
        8'h5A: rc = 6'o60; 8'h76: rc = 6'o62; 8'h29: rc = 6'o67;
        8'h12: rc = 6'o70; 8'h59: rc = 6'o70;  // both shifts share one key
        default: hit = 1'b0;
      endcase
    end else begin
      case (code)
        8'h5A: rc = 6'o60;  // keypad ENTER
        8'h6C: rc = 6'o61;  // Home -> CLEAR
        8'h75: rc = 6'o63;
        8'h72: rc = 6'o64;
        8'h6B: rc = 6'o65;
        8'h74: rc = 6'o66;
        default: hit = 1'b0;
      endcase
    end
  end

  assign row = rc[5:3];
  assign col = rc[2:0];

endmodule

// File: rtl/trs80_keyboard.sv
// PS/2 receiver + scancode decoder maintaining the TRS-80 Model I 8x8 key matrix.
// Latency: matrix visible on keyboard_dout 2 cycles after the stop-bit strobe; reads are combinational.
// Backpressure: none; PS/2 is free-running, malformed or stalled frames are dropped.
//   clock/reset        : system clock, async active-high reset
//   ps2_clk/ps2_data   : raw PS/2 lines, asynchronous to clock
//   bus (slave)        : CPU row select in, pressed-key row data out
module trs80_keyboard
  import trs80_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = FILTER_LEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  trs80_keyboard_if.slave   bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  // ---------------- input conditioning ----------------
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] flt_cnt_q;
  logic          clk_s, dat_s, strobe;

  assign clk_s  = clk_sync_q[1];
  assign dat_s  = dat_sync_q[1];
  assign strobe = filt_prev_q & ~filt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      flt_cnt_q   <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], ps2_data};
      filt_prev_q <= filt_q;
      // Count consecutive samples that disagree with the filtered level
      if (clk_s == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        filt_q    <= clk_s;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  // ---------------- receiver FSM ----------------
  rx_state_t     state_q, state_d;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic          parity_q;
  logic [TW-1:0] to_cnt_q;
  logic          timeout, accept, frame_err;
  logic          byte_valid_q, rx_err_q;

  always_comb begin
    state_d   = state_q;
    timeout   = 1'b0;
    accept    = 1'b0;
    frame_err = 1'b0;
    // A strobe in the expiry cycle takes priority over the timeout
    if (state_q != RX_IDLE && !strobe && to_cnt_q == TO_LAST) begin
      state_d = RX_IDLE;
      timeout = 1'b1;
    end else if (strobe) begin
      case (state_q)
        RX_IDLE:   if (!dat_s) state_d = RX_DATA;
        RX_DATA:   if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        RX_PARITY: state_d = RX_STOP;
        RX_STOP: begin
          state_d = RX_IDLE;
          // Odd parity over data + parity bit, stop bit must be high
          if (dat_s && (^{shift_q, parity_q})) accept = 1'b1;
          else                                 frame_err = 1'b1;
        end
        default:   state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RX_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_valid_q <= accept;
      rx_err_q     <= timeout | frame_err;

      if (state_q == RX_IDLE || strobe || timeout) to_cnt_q <= '0;
      else                                         to_cnt_q <= to_cnt_q + 1'b1;

      if (timeout) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else if (strobe) begin
        case (state_q)
          RX_IDLE:   bit_cnt_q <= '0;
          RX_DATA: begin
            shift_q   <= {dat_s, shift_q[7:1]};  // LSB arrives first
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          RX_PARITY: parity_q <= dat_s;
          default:   ;
        endcase
      end
    end
  end

  // ---------------- decoder + matrix ----------------
  // shift_q still holds the accepted byte while byte_valid_q is high
  logic            ext_q, brk_q;
  logic [7:0][7:0] matrix_q;
  logic            km_hit;
  row_t            km_row;
  col_t            km_col;

  trs80_keymap u_keymap (
    .ext  (ext_q),
    .code (shift_q),
    .hit  (km_hit),
    .row  (km_row),
    .col  (km_col)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      matrix_q <= '0;
    end else if (rx_err_q) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byte_valid_q) begin
      if (shift_q == SC_EXT) begin
        ext_q <= 1'b1;
      end else if (shift_q == SC_BRK) begin
        brk_q <= 1'b1;
      end else if (shift_q == SC_BAT_OK && !ext_q && !brk_q) begin
        matrix_q <= '0;
      end else begin
        if (km_hit) matrix_q[km_row][km_col] <= ~brk_q;
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  // ---------------- read mux ----------------
  logic [7:0] rd_dat;

  always_comb begin
    rd_dat = '0;
    for (int n = 0; n < 8; n++) begin
      if (bus.cpu_addr[n]) rd_dat = rd_dat | matrix_q[n];
    end
    if (bus.keyboard_cs_n) rd_dat = '0;
  end

  assign bus.keyboard_dout = rd_dat;

endmodule
